// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access.
// Data wins ties, but a bounded streak of data grants lets a waiting fetch through.
module memory_arbiter #(
    parameter int TIMEOUT     = 15,
    parameter int DSTREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(DSTREAK_MAX + 1);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam logic [TW-1:0] TCNT_MAX   = TW'(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IGRANT = 2'd1,
        ST_DGRANT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcnt_inc;
    logic [SW-1:0] r_dstreak;
    logic          r_terr;
    logic          w_dreq;
    logic          w_own_req;
    logic          w_granted;
    logic          w_done;
    logic          w_abort;

    assign w_dreq     = dREN | dWEN;
    assign w_granted  = (r_state != ST_IDLE);
    assign w_tcnt_inc = r_tcnt + {{(TW-1){1'b0}}, 1'b1};
    assign w_done     = w_granted & w_own_req & (ramstate == RS_ACCESS);
    // Completion takes precedence over both ERROR and the timeout limit.
    assign w_abort    = w_granted & w_own_req & ~w_done &
                        ((ramstate == RS_ERROR) | (w_tcnt_inc == TCNT_MAX));

    assign iload       = ramload;
    assign dload       = ramload;
    assign timeout_err = r_terr;

    // Live request of whichever requester currently owns the RAM.
    always_comb begin
        w_own_req = 1'b0;
        case (r_state)
            ST_IGRANT: w_own_req = iREN;
            ST_DGRANT: w_own_req = w_dreq;
            default:   w_own_req = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection with data priority limited by the streak count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_dreq && ((r_dstreak < STREAK_MAX) || !iREN)) begin
                    w_next = ST_DGRANT;
                end else if (iREN) begin
                    w_next = ST_IGRANT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_IGRANT, ST_DGRANT: begin
                if (!w_own_req || w_done || w_abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = r_state;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // RAM strobes, address/data steering and requester wait flags.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            ST_IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~w_done;
            end
            ST_DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~w_done;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    // Grant-cycle timeout counter, held at zero outside a grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tcnt <= {TW{1'b0}};
        end else if (!w_granted || (w_next == ST_IDLE)) begin
            r_tcnt <= {TW{1'b0}};
        end else if (ramstate != RS_ACCESS) begin
            r_tcnt <= w_tcnt_inc;
        end
    end

    // Consecutive data-completion streak, reset by any fetch completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dstreak <= {SW{1'b0}};
        end else if (w_done && (r_state == ST_IGRANT)) begin
            r_dstreak <= {SW{1'b0}};
        end else if (w_done && (r_state == ST_DGRANT) && (r_dstreak != STREAK_MAX)) begin
            r_dstreak <= r_dstreak + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle abort pulse, visible the cycle after the abort.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_terr <= 1'b0;
        end else begin
            r_terr <= w_abort;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: grant order, completion timing, aborts.
module tb_memory_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        timeout_err;

    int total;
    int bad;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    memory_arbiter #(.TIMEOUT(15), .DSTREAK_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
        #2;
        total++; if (iwait !== 1'b1 || dwait !== 1'b1) begin bad++; $display("FAIL reset_wait got=%b%b exp=11", iwait, dwait); end
        total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin bad++; $display("FAIL reset_ram got=%b%b %h %h exp=00 0 0", ramREN, ramWEN, ramaddr, ramstore); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
        step();
        nRST = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h1234_5678; ramstate = BUSY;
        #3;
        total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL reset_idle_strobe got=%b exp=0", ramWEN); end
        step(); #2;
        total++; if (ramWEN !== 1'b1 || ramaddr !== 32'h300) begin bad++; $display("FAIL reset_dgrant got=%b %h exp=1 300", ramWEN, ramaddr); end
        nRST = 1'b0;
        #1;
        total++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1 || dwait !== 1'b1) begin bad++; $display("FAIL reset_async got=%b %h %b%b exp=0 0 11", ramWEN, ramaddr, iwait, dwait); end
        ramstate = ACCESS;
        step(); #3;
        total++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin bad++; $display("FAIL reset_no_complete got=%b %b exp=1 0", dwait, ramWEN); end
        nRST = 1'b1; dWEN = 1'b0; ramstate = FREE;
        step(); #3;
        total++; if (ramWEN !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_after got=%b %b exp=0 0", ramWEN, timeout_err); end
    endtask

    task automatic test_single_fetch();
        step();
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        #3;
        total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin bad++; $display("FAIL fetch_c0 got=%b %b exp=0 1", ramREN, iwait); end
        for (int c = 1; c <= 2; c++) begin
            step(); #3;
            total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin bad++; $display("FAIL fetch_busy c=%0d got=%b %h %b exp=1 40 1", c, ramREN, ramaddr, iwait); end
        end
        step();
        ramstate = ACCESS; ramload = 32'h8C22_0004;
        #3;
        total++; if (iwait !== 1'b0 || iload !== 32'h8C22_0004 || dwait !== 1'b1) begin bad++; $display("FAIL fetch_done got=%b %h %b exp=0 8c220004 1", iwait, iload, dwait); end
        step();
        iREN = 1'b0; ramstate = FREE;
        #3;
        total++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1) begin bad++; $display("FAIL fetch_idle got=%b %h %b exp=0 0 1", ramREN, ramaddr, iwait); end
    endtask

    task automatic test_priority();
        step();
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; ramstate = ACCESS;
        step(); #3;
        total++; if (ramaddr !== 32'h100 || ramREN !== 1'b1 || dwait !== 1'b0 || iwait !== 1'b1) begin bad++; $display("FAIL prio_data got=%h %b %b %b exp=100 1 0 1", ramaddr, ramREN, dwait, iwait); end
        step();
        dREN = 1'b0;
        #3;
        total++; if (ramaddr !== 32'h0 || ramREN !== 1'b0) begin bad++; $display("FAIL prio_dead got=%h %b exp=0 0", ramaddr, ramREN); end
        step(); #3;
        total++; if (ramaddr !== 32'h80 || iwait !== 1'b0) begin bad++; $display("FAIL prio_fetch got=%h %b exp=80 0", ramaddr, iwait); end
        step();
        iREN = 1'b0;
    endtask

    task automatic test_fairness();
        logic [31:0] exp_addr [12];
        exp_addr = '{32'h500, 32'h0, 32'h500, 32'h0, 32'h500, 32'h0, 32'h500, 32'h0,
                     32'h600, 32'h0, 32'h500, 32'h0};
        step();
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'h1; iREN = 1'b1; iaddr = 32'h600; ramstate = ACCESS;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 12) begin dWEN = 1'b0; iREN = 1'b0; end
            #3;
            total++; if (ramaddr !== exp_addr[c-1]) begin bad++; $display("FAIL fair c=%0d got=%h exp=%h", c, ramaddr, exp_addr[c-1]); end
        end
    endtask

    task automatic test_timeout();
        step();
        iREN = 1'b1; iaddr = 32'h700; ramstate = BUSY;
        for (int c = 1; c <= 15; c++) begin
            step(); #3;
            total++; if (ramREN !== 1'b1 || iwait !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_grant c=%0d got=%b %b %b exp=1 1 0", c, ramREN, iwait, timeout_err); end
        end
        step();
        iREN = 1'b0;
        #3;
        total++; if (ramREN !== 1'b0 || timeout_err !== 1'b1 || iwait !== 1'b1) begin bad++; $display("FAIL tmo_abort got=%b %b %b exp=0 1 1", ramREN, timeout_err, iwait); end
        step(); #3;
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%b exp=0", timeout_err); end
    endtask

    task automatic test_timeout_edge();
        step();
        iREN = 1'b1; iaddr = 32'h710; ramstate = BUSY;
        for (int c = 1; c <= 14; c++) step();
        ramstate = ACCESS;
        #3;
        total++; if (iwait !== 1'b0 || ramaddr !== 32'h710) begin bad++; $display("FAIL tmo_edge_done got=%b %h exp=0 710", iwait, ramaddr); end
        step();
        iREN = 1'b0; ramstate = FREE;
        #3;
        total++; if (timeout_err !== 1'b0 || ramREN !== 1'b0) begin bad++; $display("FAIL tmo_edge_noerr got=%b %b exp=0 0", timeout_err, ramREN); end
    endtask

    task automatic test_error();
        step();
        dREN = 1'b1; daddr = 32'h900; ramstate = ERROR;
        step(); #3;
        total++; if (dwait !== 1'b1 || ramREN !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL err_grant got=%b %b %b exp=1 1 0", dwait, ramREN, timeout_err); end
        step();
        dREN = 1'b0; ramstate = FREE;
        #3;
        total++; if (timeout_err !== 1'b1 || ramREN !== 1'b0 || dwait !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b %b %b exp=1 0 1", timeout_err, ramREN, dwait); end
    endtask

    task automatic test_write_beats_read();
        step();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
        step(); #3;
        total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h200 || dwait !== 1'b1) begin bad++; $display("FAIL wr_grant got=%b%b %h %h %b exp=10 deadbeef 200 1", ramWEN, ramREN, ramstore, ramaddr, dwait); end
        step();
        ramstate = ACCESS;
        #3;
        total++; if (dwait !== 1'b0 || ramWEN !== 1'b1) begin bad++; $display("FAIL wr_done got=%b %b exp=0 1", dwait, ramWEN); end
        step();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        #3;
        total++; if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin bad++; $display("FAIL wr_idle got=%b %h exp=0 0", ramWEN, ramstore); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_fairness();
        test_timeout();
        test_timeout_edge();
        test_error();
        test_write_beats_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
